// File: rtl/cpu_pkg.sv
// Shared CPU constants and the PC-select enum used by pc_gen and its debug taps.
package cpu_pkg;

  localparam int unsigned PC_INC           = 4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_TRAP_VEC = 32'h0000_0100;

  typedef enum logic [2:0] {
    PC_HOLD,
    PC_TRAP,
    PC_REDIR,
    PC_NEXT,
    PC_RAS
  } pc_sel_e;

  // True for the selections that come from a normal (non-forced) PC update.
  function automatic logic is_update(pc_sel_e sel);
    return (sel == PC_NEXT) || (sel == PC_RAS);
  endfunction

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack: push/pop at a single top pointer, count saturates
// at RAS_DEPTH so an overflow silently overwrites the oldest entry.
module ras_stack #(
  parameter int XLEN      = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic                         pop,
  input  logic [XLEN-1:0]              push_data,
  output logic [XLEN-1:0]              top_data,
  output logic [$clog2(RAS_DEPTH):0]   count,
  output logic                         empty,
  output logic                         full
);

  localparam int         PW       = $clog2(RAS_DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW + 1)'(RAS_DEPTH);

  logic [XLEN-1:0] r_mem [RAS_DEPTH];
  logic [PW-1:0]   r_top;
  logic [PW:0]     r_count;

  logic            w_pop;
  logic [PW-1:0]   w_top_inc;
  logic [PW-1:0]   w_top_dec;

  assign w_pop     = pop & (r_count != '0);
  // Depth is a power of two, so pointer arithmetic wraps for free.
  assign w_top_inc = r_top + PW'(1);
  assign w_top_dec = r_top - PW'(1);

  // NOTE: the entries are cleared on reset because a return after reset must never see stale data.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_top   <= '0;
      r_count <= '0;
      for (int i = 0; i < RAS_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (push && w_pop) begin
      r_mem[r_top] <= push_data;
    end else if (push) begin
      r_mem[w_top_inc] <= push_data;
      r_top            <= w_top_inc;
      if (r_count != FULL_CNT) begin
        r_count <= r_count + (PW + 1)'(1);
      end
    end else if (w_pop) begin
      r_top   <= w_top_dec;
      r_count <= r_count - (PW + 1)'(1);
    end
  end

  assign top_data = r_mem[r_top];
  assign count    = r_count;
  assign empty    = (r_count == '0);
  assign full     = (r_count == FULL_CNT);

endmodule

// File: rtl/pc_gen.sv
// Program-counter unit: prioritised trap/redirect/stall/update select, PC register and RAS.
// Optional alignment checking of redirect/update targets is enabled by PC_ALIGN_CHECK_EN.
module pc_gen
  import cpu_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = XLEN'(DEFAULT_RESET_PC),
  parameter logic [31:0]     TRAP_VEC  = DEFAULT_TRAP_VEC,
  parameter int              RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            trap,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            stall,
  input  logic            pc_write,
  input  logic            pc_write_not_cond,
  input  logic            alu_bcond,
  input  logic [XLEN-1:0] next_pc,
  input  logic            call_valid,
  input  logic            ret_valid,
  output logic [XLEN-1:0] current_pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic            ras_empty,
  output logic            ras_full,
  output logic            ret_miss
`ifdef PC_ALIGN_CHECK_EN
  ,
  output logic            misalign
`endif
);

  localparam logic [XLEN-1:0] TRAP_PC = XLEN'(TRAP_VEC);
  localparam int              CW      = $clog2(RAS_DEPTH) + 1;

  logic [XLEN-1:0] r_pc;
  logic            r_ret_miss;

  pc_sel_e         w_sel;
  logic            w_upd;
  logic            w_ras_has_data;
  logic [XLEN-1:0] w_ras_top;
  logic [CW-1:0]   w_ras_count;
  logic [XLEN-1:0] w_pc_d;
  logic            w_bad_target;
  logic            w_commit;
  logic            w_push;
  logic            w_pop;
  logic            w_ret_miss_d;

  assign w_upd          = pc_write | (pc_write_not_cond & ~alu_bcond);
  assign w_ras_has_data = (w_ras_count != '0);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_sel = PC_HOLD;
    if (trap) begin
      w_sel = PC_TRAP;
    end else if (redirect_valid) begin
      w_sel = PC_REDIR;
    end else if (stall) begin
      w_sel = PC_HOLD;
    end else if (w_upd) begin
      w_sel = (ret_valid && w_ras_has_data) ? PC_RAS : PC_NEXT;
    end
  end

  always_comb begin
    w_pc_d = r_pc;
    case (w_sel)
      PC_TRAP:  w_pc_d = TRAP_PC;
      PC_REDIR: w_pc_d = redirect_pc;
      PC_NEXT:  w_pc_d = next_pc;
      PC_RAS:   w_pc_d = w_ras_top;
      default:  w_pc_d = r_pc;
    endcase
  end

`ifdef PC_ALIGN_CHECK_EN
  // The trap vector is trusted; only redirect and normal-update targets are checked.
  assign w_bad_target = ((w_sel == PC_REDIR) || is_update(w_sel)) && (w_pc_d[1:0] != 2'b00);
`else
  assign w_bad_target = 1'b0;
`endif

  assign w_commit     = is_update(w_sel) & ~w_bad_target;
  assign w_push       = w_commit & call_valid;
  assign w_pop        = w_commit & (w_sel == PC_RAS);
  assign w_ret_miss_d = w_commit & ret_valid & ~w_ras_has_data;

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc       <= RESET_PC;
      r_ret_miss <= 1'b0;
    end else begin
      if (!w_bad_target) begin
        r_pc <= w_pc_d;
      end
      r_ret_miss <= w_ret_miss_d;
    end
  end

`ifdef PC_ALIGN_CHECK_EN
  logic r_misalign;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_misalign <= 1'b0;
    end else begin
      r_misalign <= w_bad_target;
    end
  end

  assign misalign = r_misalign;
`endif

  ras_stack #(
    .XLEN      (XLEN),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .reset     (reset),
    .push      (w_push),
    .pop       (w_pop),
    .push_data (pc_plus4),
    .top_data  (w_ras_top),
    .count     (w_ras_count),
    .empty     (ras_empty),
    .full      (ras_full)
  );

  assign current_pc = r_pc;
  assign pc_plus4   = r_pc + XLEN'(PC_INC);
  assign ret_miss   = r_ret_miss;

endmodule
